// File: rtl/pic_pkg.sv
// pic_pkg: command codes, init-sequence state encoding and control-word bit positions for the 8259-style sequencer
package pic_pkg;

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_ICW1 = 3'd1;
    localparam logic [2:0] CMD_ICW2 = 3'd2;
    localparam logic [2:0] CMD_ICW3 = 3'd3;
    localparam logic [2:0] CMD_ICW4 = 3'd4;
    localparam logic [2:0] CMD_OCW1 = 3'd5;
    localparam logic [2:0] CMD_OCW2 = 3'd6;
    localparam logic [2:0] CMD_OCW3 = 3'd7;

    localparam logic [2:0] ST_UNINIT    = 3'd0;
    localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;

    localparam int IC4     = 0;
    localparam int SNGL    = 1;
    localparam int ICW1_ID = 4;
    localparam int OCW3_ID = 3;

endpackage

// File: rtl/pic_bus_sync.sv
// pic_bus_sync: N-stage synchroniser with per-bit reset value; zero stages is a pass-through
module pic_bus_sync #(
    parameter int W = 1,
    parameter int STAGES = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_pass
            assign q = d;
        end else begin : g_sync
            logic [W-1:0] r [STAGES];
            always_ff @(posedge clk or negedge reset)
                if (!reset) begin
                    for (int i = 0; i < STAGES; i++) r[i] <= RST_VAL;
                end else begin
                    r[0] <= d;
                    for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
                end
            assign q = r[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/pic_rw_cmd_sequencer.sv
// pic_rw_cmd_sequencer: synchronised 8259 bus read/write front end with ICW/OCW decode sequencer
module pic_rw_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_select,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic                  A0,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  read_flag,
    output logic                  read_start,
    output logic                  read_a0,
    output logic                  write_flag,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  cmd_valid,
    output logic [2:0]            cmd_code,
    output logic                  cmd_error,
    output logic                  init_done,
    output logic                  ic4_flag,
    output logic                  sngl_flag
);

    logic cs_s, rd_s, wr_s, a0_s;
    logic [DATA_WIDTH-1:0] d_s;
    logic wr_prev, cs_prev, det, hold_a0, icw1, err, rd_act;
    logic [DATA_WIDTH-1:0] hold_d;
    logic [2:0] state, nxt, code;

    pic_bus_sync #(
        .W(DATA_WIDTH + 4),
        .STAGES(SYNC_STAGES),
        .RST_VAL({3'b111, {(DATA_WIDTH + 1){1'b0}}})
    ) u_sync (
        .clk(clk),
        .reset(reset),
        .d({chip_select, read_enable, write_enable, A0, data_in}),
        .q({cs_s, rd_s, wr_s, a0_s, d_s})
    );

    assign rd_act = !cs_s && !rd_s && wr_s;

    // In READY an A0=0 word with D4 and D3 both set is rejected rather than restarting initialisation
    always_comb begin
        icw1 = !hold_a0 && hold_d[ICW1_ID] && !(state == ST_READY && hold_d[OCW3_ID]);
        nxt = state;
        code = CMD_NONE;
        err = 1'b0;
        if (icw1) begin
            nxt = ST_WAIT_ICW2;
            code = CMD_ICW1;
        end else if (state == ST_UNINIT || (!hold_a0 && state != ST_READY)) begin
            err = 1'b1;
        end else if (state == ST_READY) begin
            err = !hold_a0 && hold_d[ICW1_ID];
            code = hold_a0 ? CMD_OCW1 : hold_d[OCW3_ID] ? CMD_OCW3 : CMD_OCW2;
        end else begin
            code = state == ST_WAIT_ICW2 ? CMD_ICW2 : state == ST_WAIT_ICW3 ? CMD_ICW3 : CMD_ICW4;
            nxt = (state == ST_WAIT_ICW2 && !sngl_flag) ? ST_WAIT_ICW3 :
                  (state != ST_WAIT_ICW4 && ic4_flag) ? ST_WAIT_ICW4 : ST_READY;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_prev <= 1'b1;
            cs_prev <= 1'b1;
            det <= 1'b0;
            hold_a0 <= 1'b0;
            hold_d <= '0;
            state <= ST_UNINIT;
            read_flag <= 1'b0;
            read_start <= 1'b0;
            read_a0 <= 1'b0;
            write_flag <= 1'b0;
            data_out <= '0;
            cmd_valid <= 1'b0;
            cmd_code <= CMD_NONE;
            cmd_error <= 1'b0;
            init_done <= 1'b0;
            ic4_flag <= 1'b0;
            sngl_flag <= 1'b0;
        end else begin
            wr_prev <= wr_s;
            cs_prev <= cs_s;
            det <= !wr_prev && wr_s && !cs_prev;
            if (!wr_s && !cs_s) begin
                hold_d <= d_s;
                hold_a0 <= a0_s;
            end
            read_flag <= rd_act;
            read_start <= rd_act && !read_flag;
            if (rd_act && !read_flag) read_a0 <= a0_s;
            write_flag <= det;
            cmd_valid <= det && !err;
            cmd_error <= det && err;
            init_done <= state == ST_READY;
            if (det) begin
                data_out <= hold_d;
                cmd_code <= err ? CMD_NONE : code;
                state <= nxt;
                if (icw1) begin
                    ic4_flag <= hold_d[IC4];
                    sngl_flag <= hold_d[SNGL];
                end
            end
        end

endmodule

// File: tb/tb_pic_rw_cmd_sequencer.sv
// tb_pic_rw_cmd_sequencer: scenario tasks plus randomized writes checked against an init-sequence queue model
module tb_pic_rw_cmd_sequencer;

    localparam int DW = 8;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic chip_select = 1'b1;
    logic read_enable = 1'b1;
    logic write_enable = 1'b1;
    logic A0 = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic read_flag, read_start, read_a0, write_flag, cmd_valid, cmd_error, init_done, ic4_flag, sngl_flag;
    logic [DW-1:0] data_out;
    logic [2:0] cmd_code;

    int checks = 0;
    int failures = 0;

    int exp_q[$];
    bit inited = 0;
    bit m_ic4 = 0;
    bit m_sngl = 0;

    always #5 clk = ~clk;

    pic_rw_cmd_sequencer #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk),
        .reset(reset),
        .chip_select(chip_select),
        .read_enable(read_enable),
        .write_enable(write_enable),
        .A0(A0),
        .data_in(data_in),
        .read_flag(read_flag),
        .read_start(read_start),
        .read_a0(read_a0),
        .write_flag(write_flag),
        .data_out(data_out),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .cmd_error(cmd_error),
        .init_done(init_done),
        .ic4_flag(ic4_flag),
        .sngl_flag(sngl_flag)
    );

    function automatic bit model_ready();
        return inited && exp_q.size() == 0;
    endfunction

    // Initialisation is a queue of still-expected ICWs; an empty queue after ICW1 means ready
    task automatic model_write(input bit a, input logic [DW-1:0] d, output bit err, output logic [2:0] code);
        bit ready;
        ready = model_ready();
        err = 0;
        code = 3'd0;
        if (!a && d[4] && !(ready && d[3])) begin
            exp_q.delete();
            exp_q.push_back(2);
            if (!d[1]) exp_q.push_back(3);
            if (d[0]) exp_q.push_back(4);
            inited = 1;
            m_ic4 = d[0];
            m_sngl = d[1];
            code = 3'd1;
        end else if (!inited) begin
            err = 1;
        end else if (!ready) begin
            if (a) code = 3'(exp_q.pop_front());
            else err = 1;
        end else if (a) begin
            code = 3'd5;
        end else if (d[4]) begin
            err = 1;
        end else begin
            code = d[3] ? 3'd7 : 3'd6;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        inited = 0;
        m_ic4 = 0;
        m_sngl = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        chip_select = 1'b1;
        read_enable = 1'b1;
        write_enable = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic do_write(input bit a, input logic [DW-1:0] d, input bit cs_low, input bit rd_too);
        bit exp_err, prev_ready, saw_rf;
        logic [2:0] exp_code;
        logic got_v, got_e, got_i4, got_sn, got_id;
        logic [2:0] got_c;
        logic [DW-1:0] got_d;
        int k;
        prev_ready = model_ready();
        saw_rf = 0;
        k = 0;
        @(negedge clk);
        chip_select = !cs_low;
        A0 = !a;
        data_in = ~d;
        write_enable = 1'b0;
        read_enable = !rd_too;
        @(negedge clk);
        saw_rf |= read_flag;
        A0 = a;
        data_in = d;
        repeat (2) begin
            @(negedge clk);
            saw_rf |= read_flag;
        end
        write_enable = 1'b1;
        read_enable = 1'b1;
        for (int i = 1; i <= 8 && k == 0; i++) begin
            @(posedge clk);
            #1;
            saw_rf |= read_flag;
            if (write_flag) begin
                k = i;
                got_v = cmd_valid;
                got_e = cmd_error;
                got_c = cmd_code;
                got_d = data_out;
                got_i4 = ic4_flag;
                got_sn = sngl_flag;
                got_id = init_done;
            end
        end
        if (cs_low) begin
            model_write(a, d, exp_err, exp_code);
            checks++;
            if (k != SS + 2) begin
                failures++;
                $display("FAIL write_latency a=%0d d=%h: got %0d edges, expected %0d", a, d, k, SS + 2);
            end
            if (k != 0) begin
                checks++;
                if (got_v !== !exp_err || got_e !== exp_err) begin
                    failures++;
                    $display("FAIL cmd_flags a=%0d d=%h: got valid=%b error=%b, expected valid=%b error=%b", a, d, got_v, got_e, !exp_err, exp_err);
                end
                if (!exp_err) begin
                    checks++;
                    if (got_c !== exp_code) begin
                        failures++;
                        $display("FAIL cmd_code a=%0d d=%h: got %0d expected %0d", a, d, got_c, exp_code);
                    end
                end
                checks++;
                if (got_d !== d) begin
                    failures++;
                    $display("FAIL data_out: got %h expected %h", got_d, d);
                end
                checks++;
                if (got_i4 !== m_ic4 || got_sn !== m_sngl) begin
                    failures++;
                    $display("FAIL icw1_flags: got ic4=%b sngl=%b expected ic4=%b sngl=%b", got_i4, got_sn, m_ic4, m_sngl);
                end
                checks++;
                if (got_id !== prev_ready) begin
                    failures++;
                    $display("FAIL init_done_at_cmd: got %b expected %b", got_id, prev_ready);
                end
                @(posedge clk);
                #1;
                checks++;
                if (write_flag !== 1'b0 || cmd_valid !== 1'b0 || cmd_error !== 1'b0) begin
                    failures++;
                    $display("FAIL pulse_width: got wf=%b cv=%b ce=%b expected all 0", write_flag, cmd_valid, cmd_error);
                end
                checks++;
                if (init_done !== model_ready()) begin
                    failures++;
                    $display("FAIL init_done_after: got %b expected %b", init_done, model_ready());
                end
            end
            if (rd_too) begin
                checks++;
                if (saw_rf) begin
                    failures++;
                    $display("FAIL rw_overlap_read_flag: got 1 expected 0");
                end
            end
        end else begin
            checks++;
            if (k != 0) begin
                failures++;
                $display("FAIL dropped_write: got write_flag at edge %0d expected none", k);
            end
        end
        @(negedge clk);
        chip_select = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read(input bit a, input bit cs_low);
        int starts, first;
        starts = 0;
        first = 0;
        @(negedge clk);
        chip_select = !cs_low;
        A0 = a;
        read_enable = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            starts += int'(read_start);
            if (read_flag && first == 0) first = i;
        end
        if (cs_low) begin
            checks++;
            if (first != SS + 1 || starts != 1) begin
                failures++;
                $display("FAIL read_start: got first=%0d starts=%0d expected first=%0d starts=1", first, starts, SS + 1);
            end
            checks++;
            if (read_a0 !== a || read_flag !== 1'b1) begin
                failures++;
                $display("FAIL read_level: got a0=%b flag=%b expected a0=%b flag=1", read_a0, read_flag, a);
            end
        end else begin
            checks++;
            if (first != 0 || starts != 0) begin
                failures++;
                $display("FAIL read_cs_high: got first=%0d starts=%0d expected 0 0", first, starts);
            end
        end
        @(negedge clk);
        read_enable = 1'b1;
        A0 = !a;
        repeat (SS + 2) @(posedge clk);
        #1;
        checks++;
        if (read_flag !== 1'b0 || (cs_low && read_a0 !== a)) begin
            failures++;
            $display("FAIL read_end: got flag=%b a0=%b expected flag=0 a0=%b", read_flag, read_a0, a);
        end
        @(negedge clk);
        chip_select = 1'b1;
    endtask

    task automatic test_reset();
        int seen;
        seen = 0;
        @(negedge clk);
        chip_select = 1'b0;
        A0 = 1'b0;
        data_in = 8'h13;
        write_enable = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({read_flag, read_start, read_a0, write_flag, cmd_valid, cmd_error, init_done, ic4_flag, sngl_flag, cmd_code, data_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {read_flag, read_start, read_a0, write_flag, cmd_valid, cmd_error, init_done, ic4_flag, sngl_flag, cmd_code, data_out});
        end
        @(negedge clk);
        write_enable = 1'b1;
        chip_select = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            seen += int'(write_flag);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_discard: got %0d write_flag pulses expected 0", seen);
        end
    endtask

    task automatic test_init_single();
        do_write(0, 8'h13, 1, 0);
        do_write(1, 8'h20, 1, 0);
        do_write(1, 8'h01, 1, 0);
    endtask

    task automatic test_init_cascade();
        do_write(0, 8'h11, 1, 0);
        do_write(1, 8'h20, 1, 0);
        do_write(1, 8'h04, 1, 0);
        do_write(1, 8'h01, 1, 0);
        do_write(1, 8'hFE, 1, 0);
        do_write(0, 8'h20, 1, 0);
        do_write(0, 8'h0B, 1, 0);
    endtask

    task automatic test_errors();
        apply_reset();
        do_write(0, 8'h20, 1, 0);
        do_write(0, 8'h13, 1, 0);
        do_write(1, 8'h20, 1, 0);
        do_write(1, 8'h01, 1, 0);
        do_write(0, 8'h18, 1, 0);
        do_write(0, 8'h11, 1, 0);
        do_write(1, 8'h20, 1, 0);
        do_write(0, 8'h13, 1, 0);
        do_write(0, 8'h05, 1, 0);
        do_write(1, 8'h20, 1, 0);
        do_write(1, 8'h01, 1, 0);
    endtask

    task automatic test_cs_high();
        do_write(1, 8'hAA, 0, 0);
        test_read(1, 0);
    endtask

    task automatic test_rw_overlap();
        do_write(0, 8'h13, 1, 1);
        do_write(1, 8'h20, 1, 1);
        do_write(1, 8'h01, 1, 1);
    endtask

    task automatic test_random();
        bit a, cs_low;
        logic [DW-1:0] d;
        for (int n = 0; n < 40; n++) begin
            a = 1'($urandom_range(0, 1));
            d = DW'($urandom);
            cs_low = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 3) == 0) begin
                a = 0;
                d[4] = 1'b1;
                d[3] = 1'b0;
            end
            do_write(a, d, cs_low, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_init_single();
        test_init_cascade();
        test_errors();
        test_cs_high();
        test_read(1, 1);
        test_read(0, 1);
        test_rw_overlap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
